// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared instruction definitions for the decode and execute stages.
// Instruction layout: {opcode[15:10], operand[9:0]}; branch offset is operand[5:0].
// Opcode groups:
//   OTHER : NOP, LDCA, LDCB, LDA, STA, LDB, STB (write no flags)
//   ALU_A : ADDA, SUBA, ANDA, ORA, XORA        (write A flags)
//   ALU_B : ADDB, SUBB, ANDB, ORB, XORB        (write B flags)
//   BR_A  : BAEQ, BANE, BACS, BACC, BAMI, BAPL (test A flags)
//   BR_B  : BBEQ, BBNE, BBCS, BBCC, BBMI, BBPL (test B flags)
// Flags are packed {N, Z, C}.
package id_stage_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned OPND_W  = 10;

    typedef enum logic [2:0] {
        ClsOther = 3'd0,
        ClsAluA  = 3'd1,
        ClsAluB  = 3'd2,
        ClsBrA   = 3'd3,
        ClsBrB   = 3'd4
    } cls_e;

    typedef enum logic [2:0] {
        CondEq = 3'd0,
        CondNe = 3'd1,
        CondCs = 3'd2,
        CondCc = 3'd3,
        CondMi = 3'd4,
        CondPl = 3'd5
    } cond_e;

    typedef enum logic {
        StRun   = 1'b0,
        StFlush = 1'b1
    } state_e;

    localparam logic [OP_W-1:0] OpNop  = 6'h00;
    localparam logic [OP_W-1:0] OpLdca = 6'h01;
    localparam logic [OP_W-1:0] OpLdcb = 6'h02;
    localparam logic [OP_W-1:0] OpLda  = 6'h03;
    localparam logic [OP_W-1:0] OpSta  = 6'h04;
    localparam logic [OP_W-1:0] OpLdb  = 6'h05;
    localparam logic [OP_W-1:0] OpStb  = 6'h06;

    localparam logic [OP_W-1:0] OpAdda = 6'h10;
    localparam logic [OP_W-1:0] OpSuba = 6'h11;
    localparam logic [OP_W-1:0] OpAnda = 6'h12;
    localparam logic [OP_W-1:0] OpOra  = 6'h13;
    localparam logic [OP_W-1:0] OpXora = 6'h14;

    localparam logic [OP_W-1:0] OpAddb = 6'h18;
    localparam logic [OP_W-1:0] OpSubb = 6'h19;
    localparam logic [OP_W-1:0] OpAndb = 6'h1A;
    localparam logic [OP_W-1:0] OpOrb  = 6'h1B;
    localparam logic [OP_W-1:0] OpXorb = 6'h1C;

    localparam logic [OP_W-1:0] OpBaeq = 6'h20;
    localparam logic [OP_W-1:0] OpBane = 6'h21;
    localparam logic [OP_W-1:0] OpBacs = 6'h22;
    localparam logic [OP_W-1:0] OpBacc = 6'h23;
    localparam logic [OP_W-1:0] OpBami = 6'h24;
    localparam logic [OP_W-1:0] OpBapl = 6'h25;

    localparam logic [OP_W-1:0] OpBbeq = 6'h28;
    localparam logic [OP_W-1:0] OpBbne = 6'h29;
    localparam logic [OP_W-1:0] OpBbcs = 6'h2A;
    localparam logic [OP_W-1:0] OpBbcc = 6'h2B;
    localparam logic [OP_W-1:0] OpBbmi = 6'h2C;
    localparam logic [OP_W-1:0] OpBbpl = 6'h2D;

    // Evaluate a branch condition against {N, Z, C}.
    function automatic logic cond_true(cond_e cond, logic [2:0] flags);
        logic res;
        case (cond)
            CondEq:  res = flags[1];
            CondNe:  res = ~flags[1];
            CondCs:  res = flags[0];
            CondCc:  res = ~flags[0];
            CondMi:  res = flags[2];
            CondPl:  res = ~flags[2];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: fetch <-> decode link.
//   iFetchedInst : instruction from fetch
//   iNew_pc      : address of iFetchedInst + 1
//   oBr_dir      : redirect address back to fetch
//   oBr_taken    : redirect strobe back to fetch
// master = fetch side, slave = decode stage.
interface id_stage_if;

    logic [id_stage_pkg::INSTR_W-1:0] iFetchedInst;
    logic [id_stage_pkg::ADDR_W-1:0]  iNew_pc;
    logic [id_stage_pkg::ADDR_W-1:0]  oBr_dir;
    logic                             oBr_taken;

    modport master (
        output iFetchedInst,
        output iNew_pc,
        input  oBr_dir,
        input  oBr_taken
    );

    modport slave (
        input  iFetchedInst,
        input  iNew_pc,
        output oBr_dir,
        output oBr_taken
    );

endinterface

// File: rtl/id_decode.sv
// id_decode: combinational opcode classifier, shared with the execute stage.
//   i_op   : opcode field
//   o_cls  : opcode class (flag writer / flag tester / other)
//   o_cond : branch condition, meaningful only for BR_A / BR_B
module id_decode
    import id_stage_pkg::*;
(
    input  logic [OP_W-1:0] i_op,
    output cls_e            o_cls,
    output cond_e           o_cond
);

    always_comb begin
        o_cls  = ClsOther;
        o_cond = CondEq;
        case (i_op)
            OpAdda, OpSuba, OpAnda, OpOra, OpXora: o_cls = ClsAluA;
            OpAddb, OpSubb, OpAndb, OpOrb, OpXorb: o_cls = ClsAluB;
            OpBaeq: begin o_cls = ClsBrA; o_cond = CondEq; end
            OpBane: begin o_cls = ClsBrA; o_cond = CondNe; end
            OpBacs: begin o_cls = ClsBrA; o_cond = CondCs; end
            OpBacc: begin o_cls = ClsBrA; o_cond = CondCc; end
            OpBami: begin o_cls = ClsBrA; o_cond = CondMi; end
            OpBapl: begin o_cls = ClsBrA; o_cond = CondPl; end
            OpBbeq: begin o_cls = ClsBrB; o_cond = CondEq; end
            OpBbne: begin o_cls = ClsBrB; o_cond = CondNe; end
            OpBbcs: begin o_cls = ClsBrB; o_cond = CondCs; end
            OpBbcc: begin o_cls = ClsBrB; o_cond = CondCc; end
            OpBbmi: begin o_cls = ClsBrB; o_cond = CondMi; end
            OpBbpl: begin o_cls = ClsBrB; o_cond = CondPl; end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: instruction decode stage with IF/ID register, branch resolution,
// wrong-path squash and flag-hazard replay.
//   clk, reset  : clock, synchronous active-high reset
//   fetch       : fetch link (instruction + next PC in, redirect out)
//   iFlagsA/B   : current {N,Z,C} of accumulators A/B from EX
//   oExOp       : registered opcode to EX (NOP when invalid)
//   oExOperand  : registered operand field to EX
//   oExValid    : registered, 1 = oExOp is a real instruction
module id_stage
    import id_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    id_stage_if.slave         fetch,
    input  logic [2:0]        iFlagsA,
    input  logic [2:0]        iFlagsB,
    output logic [OP_W-1:0]   oExOp,
    output logic [OPND_W-1:0] oExOperand,
    output logic              oExValid
);

    logic [INSTR_W-1:0] r_inst;
    logic [ADDR_W-1:0]  r_pc1;
    state_e             r_state;
    logic               r_ex_wr_a;
    logic               r_ex_wr_b;

    logic [OP_W-1:0]    w_op;
    cls_e               w_cls;
    cond_e              w_cond;
    logic               w_br_a;
    logic               w_br_b;
    logic               w_run;
    logic [2:0]         w_flags;
    logic               w_hazard;
    logic               w_cond_taken;
    logic [ADDR_W-1:0]  w_target;

    assign w_op = r_inst[INSTR_W-1 -: OP_W];

    id_decode u_decode (
        .i_op   (w_op),
        .o_cls  (w_cls),
        .o_cond (w_cond)
    );

    assign w_br_a   = (w_cls == ClsBrA);
    assign w_br_b   = (w_cls == ClsBrB);
    assign w_run    = (r_state == StRun);
    assign w_flags  = w_br_b ? iFlagsB : iFlagsA;
    // Flags the branch needs are still being produced by the op now in EX.
    assign w_hazard = w_run & ((w_br_a & r_ex_wr_a) | (w_br_b & r_ex_wr_b));
    assign w_cond_taken = w_run & (w_br_a | w_br_b) & cond_true(w_cond, w_flags);
    // Wraps modulo 2^ADDR_W.
    assign w_target = r_pc1 + ADDR_W'(r_inst[5:0]);

    // Redirect; a concurrent reset drops it.
    always_comb begin
        fetch.oBr_taken = 1'b0;
        fetch.oBr_dir   = '0;
        if (!reset) begin
            if (w_hazard) begin
                fetch.oBr_taken = 1'b1;
                fetch.oBr_dir   = r_pc1 - ADDR_W'(1);
            end else if (w_cond_taken) begin
                fetch.oBr_taken = 1'b1;
                fetch.oBr_dir   = w_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inst     <= {OpNop, {OPND_W{1'b0}}};
            r_pc1      <= '0;
            r_state    <= StRun;
            oExOp      <= OpNop;
            oExOperand <= '0;
            oExValid   <= 1'b0;
            r_ex_wr_a  <= 1'b0;
            r_ex_wr_b  <= 1'b0;
        end else begin
            // Fetch has no enable: the IF/ID register always loads.
            r_inst <= fetch.iFetchedInst;
            r_pc1  <= fetch.iNew_pc;
            case (r_state)
                StRun: begin
                    if (w_hazard) begin
                        oExOp      <= OpNop;
                        oExOperand <= '0;
                        oExValid   <= 1'b0;
                        r_ex_wr_a  <= 1'b0;
                        r_ex_wr_b  <= 1'b0;
                        r_state    <= StFlush;
                    end else begin
                        oExOp      <= w_op;
                        oExOperand <= r_inst[OPND_W-1:0];
                        oExValid   <= 1'b1;
                        r_ex_wr_a  <= (w_cls == ClsAluA);
                        r_ex_wr_b  <= (w_cls == ClsAluB);
                        r_state    <= w_cond_taken ? StFlush : StRun;
                    end
                end
                default: begin
                    // Instruction in ID is wrong-path.
                    oExOp      <= OpNop;
                    oExOperand <= '0;
                    oExValid   <= 1'b0;
                    r_ex_wr_a  <= 1'b0;
                    r_ex_wr_b  <= 1'b0;
                    r_state    <= StRun;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;
    import id_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  flags_a;
    logic [2:0]  flags_b;
    logic [5:0]  ex_op;
    logic [9:0]  ex_opnd;
    logic        ex_valid;

    id_stage_if u_if ();

    id_stage u_dut (
        .clk        (clk),
        .reset      (rst),
        .fetch      (u_if),
        .iFlagsA    (flags_a),
        .iFlagsB    (flags_b),
        .oExOp      (ex_op),
        .oExOperand (ex_opnd),
        .oExValid   (ex_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(logic [5:0] op, logic [9:0] opnd);
        return {op, opnd};
    endfunction

    typedef struct {
        logic        r;
        logic [15:0] ins;
        logic [9:0]  npc;
        logic [2:0]  fa;
        logic [2:0]  fb;
        logic        e_taken;
        logic [9:0]  e_dir;
        logic [5:0]  e_op;
        logic [9:0]  e_opnd;
        logic        e_val;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic r, input logic [15:0] ins, input logic [9:0] npc,
                       input logic [2:0] fa, input logic [2:0] fb, input logic et,
                       input logic [9:0] ed, input logic [5:0] eop, input logic [9:0] eopnd,
                       input logic ev);
        tbl.push_back('{r, ins, npc, fa, fb, et, ed, eop, eopnd, ev});
    endtask

    // Reference model, phrased in terms of the instruction encoding:
    // branches are 10_s_ccc with cond 0..5, flag writers are 01_s_fff with fff 0..4.
    function automatic bit m_is_br(logic [5:0] op);
        return (op[5:4] == 2'b10) && (op[2:0] < 3'd6);
    endfunction

    function automatic bit m_writes(logic [5:0] op, logic side);
        return (op[5:4] == 2'b01) && (op[3] == side) && (op[2:0] <= 3'd4);
    endfunction

    function automatic bit m_cond(logic [5:0] op, logic [2:0] f);
        case (op[2:0])
            3'd0:    return f[1];
            3'd1:    return !f[1];
            3'd2:    return f[0];
            3'd3:    return !f[0];
            3'd4:    return f[2];
            default: return !f[2];
        endcase
    endfunction

    logic [15:0] imem [1024];
    logic [5:0]  pool [$];

    initial begin
        logic [15:0] m_id_inst;
        logic [9:0]  m_id_pc1;
        bit          m_squash;
        logic [5:0]  m_ex_op;
        logic [9:0]  m_ex_opnd;
        bit          m_ex_val;
        logic [9:0]  m_pc;
        bit          e_taken;
        logic [9:0]  e_dir;
        bit          hz;
        logic [5:0]  id_op;
        logic        side;

        // Directed sequences, one row per cycle.
        row(1, mk(OpLdca, 5),  1,    3'b000, 3'b000, 0, 0,  OpNop,  0,  0);
        row(1, mk(OpLdca, 5),  1,    3'b000, 3'b000, 0, 0,  OpNop,  0,  0);
        row(0, mk(OpLdca, 5),  1,    3'b000, 3'b000, 0, 0,  OpNop,  0,  0);
        row(0, mk(OpLdcb, 5),  2,    3'b000, 3'b000, 0, 0,  OpNop,  0,  1);
        row(0, mk(OpNop, 0),   3,    3'b000, 3'b000, 0, 0,  OpLdca, 5,  1);
        row(0, mk(OpNop, 0),   4,    3'b000, 3'b000, 0, 0,  OpLdcb, 5,  1);
        row(0, mk(OpBacs, 50), 9,    3'b000, 3'b000, 0, 0,  OpNop,  0,  1);
        row(0, mk(OpAdda, 3),  10,   3'b001, 3'b000, 1, 59, OpNop,  0,  1);
        row(0, mk(OpNop, 0),   60,   3'b001, 3'b000, 0, 0,  OpBacs, 50, 1);
        row(0, mk(OpBbeq, 7),  61,   3'b000, 3'b000, 0, 0,  OpNop,  0,  0);
        row(0, mk(OpLdcb, 9),  62,   3'b000, 3'b101, 0, 0,  OpNop,  0,  1);
        row(0, mk(OpAdda, 1),  63,   3'b000, 3'b000, 0, 0,  OpBbeq, 7,  1);
        row(0, mk(OpBaeq, 4),  64,   3'b000, 3'b000, 0, 0,  OpLdcb, 9,  1);
        row(0, mk(OpLdca, 7),  65,   3'b010, 3'b000, 1, 63, OpAdda, 1,  1);
        row(0, mk(OpBaeq, 4),  64,   3'b010, 3'b000, 0, 0,  OpNop,  0,  0);
        row(0, mk(OpNop, 0),   65,   3'b010, 3'b000, 1, 68, OpNop,  0,  0);
        row(0, mk(OpBacs, 10), 1021, 3'b000, 3'b000, 0, 0,  OpBaeq, 4,  1);
        row(0, mk(OpBaeq, 0),  1022, 3'b001, 3'b000, 1, 7,  OpNop,  0,  0);
        row(0, mk(OpBacs, 2),  8,    3'b011, 3'b000, 0, 0,  OpBacs, 10, 1);
        row(0, mk(OpNop, 0),   9,    3'b001, 3'b000, 1, 10, OpNop,  0,  0);
        row(1, mk(OpNop, 0),   11,   3'b011, 3'b000, 0, 0,  OpBacs, 2,  1);
        row(0, mk(OpBacs, 3),  1,    3'b001, 3'b000, 0, 0,  OpNop,  0,  0);
        row(0, mk(OpNop, 0),   5,    3'b001, 3'b000, 1, 4,  OpNop,  0,  1);
        row(0, mk(OpBacs, 3),  5,    3'b001, 3'b000, 0, 0,  OpBacs, 3,  1);
        row(1, mk(OpNop, 0),   6,    3'b001, 3'b000, 0, 0,  OpNop,  0,  0);
        row(0, mk(OpNop, 0),   1,    3'b000, 3'b000, 0, 0,  OpNop,  0,  0);

        // Unchecked power-on reset cycle.
        rst = 1'b1;
        u_if.iFetchedInst = '0;
        u_if.iNew_pc = '0;
        flags_a = '0;
        flags_b = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            rst               = tbl[i].r;
            u_if.iFetchedInst = tbl[i].ins;
            u_if.iNew_pc      = tbl[i].npc;
            flags_a           = tbl[i].fa;
            flags_b           = tbl[i].fb;
            #4;
            chk($sformatf("dir row%0d taken", i), 32'(u_if.oBr_taken), 32'(tbl[i].e_taken));
            chk($sformatf("dir row%0d dir", i),   32'(u_if.oBr_dir),   32'(tbl[i].e_dir));
            chk($sformatf("dir row%0d op", i),    32'(ex_op),          32'(tbl[i].e_op));
            chk($sformatf("dir row%0d opnd", i),  32'(ex_opnd),        32'(tbl[i].e_opnd));
            chk($sformatf("dir row%0d valid", i), 32'(ex_valid),       32'(tbl[i].e_val));
            @(posedge clk);
            #1;
        end

        // Random program and flags against the model.
        pool = '{OpNop, OpLdca, OpLdcb, OpLda, OpAdda, OpSuba, OpXora, OpAddb, OpSubb,
                 OpOrb, OpBaeq, OpBane, OpBacs, OpBacc, OpBami, OpBapl, OpBbeq, OpBbne,
                 OpBbcs, OpBbcc, OpBbmi, OpBbpl};
        for (int a = 0; a < 1024; a++) begin
            logic [5:0] op;
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            else op = pool[$urandom_range(0, pool.size() - 1)];
            imem[a] = {op, 10'($urandom)};
        end

        rst = 1'b1;
        @(posedge clk);
        #1;
        m_id_inst = 16'h0000;
        m_id_pc1  = '0;
        m_squash  = 0;
        m_ex_op   = 6'd0;
        m_ex_opnd = '0;
        m_ex_val  = 0;
        m_pc      = '0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst               = ($urandom_range(0, 149) == 0);
            u_if.iFetchedInst = imem[m_pc];
            u_if.iNew_pc      = m_pc + 10'd1;
            flags_a           = 3'($urandom);
            flags_b           = 3'($urandom);

            id_op   = m_id_inst[15:10];
            side    = id_op[3];
            e_taken = 0;
            e_dir   = '0;
            hz      = 0;
            if (!m_squash && m_is_br(id_op)) begin
                hz = m_ex_val && m_writes(m_ex_op, side);
                if (hz) begin
                    e_taken = 1;
                    e_dir   = m_id_pc1 - 10'd1;
                end else if (m_cond(id_op, side ? flags_b : flags_a)) begin
                    e_taken = 1;
                    e_dir   = 10'((int'(m_id_pc1) + int'(m_id_inst[5:0])) % 1024);
                end
            end
            if (rst) begin
                e_taken = 0;
                e_dir   = '0;
            end

            #4;
            chk($sformatf("rnd c%0d taken", cyc), 32'(u_if.oBr_taken), 32'(e_taken));
            chk($sformatf("rnd c%0d dir", cyc),   32'(u_if.oBr_dir),   32'(e_dir));
            chk($sformatf("rnd c%0d op", cyc),    32'(ex_op),          32'(m_ex_op));
            chk($sformatf("rnd c%0d opnd", cyc),  32'(ex_opnd),        32'(m_ex_opnd));
            chk($sformatf("rnd c%0d valid", cyc), 32'(ex_valid),       32'(m_ex_val));

            if (rst) begin
                m_id_inst = 16'h0000;
                m_id_pc1  = '0;
                m_squash  = 0;
                m_ex_op   = 6'd0;
                m_ex_opnd = '0;
                m_ex_val  = 0;
                m_pc      = '0;
            end else begin
                if (m_squash || hz) begin
                    m_ex_op   = 6'd0;
                    m_ex_opnd = '0;
                    m_ex_val  = 0;
                end else begin
                    m_ex_op   = id_op;
                    m_ex_opnd = m_id_inst[9:0];
                    m_ex_val  = 1;
                end
                m_squash  = e_taken;
                m_id_inst = u_if.iFetchedInst;
                m_id_pc1  = u_if.iNew_pc;
                m_pc      = e_taken ? e_dir : m_pc + 10'd1;
            end
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
